venmac_param: RTL and testbench
===============================

VENMAC_PARAM -- requirements
Module: venmac_param

Interface
REQ-001 SHALL provide parameter N_ITEMS, default 2: number of product channels, 1..8.
REQ-002 SHALL provide parameter CW, default 6: credit register width in bits.
REQ-003 SHALL provide parameter A_VAL, default 1: credit units added by one coin_a event.
REQ-004 SHALL provide parameter B_VAL, default 5: credit units added by one coin_b event.
REQ-005 SHALL provide parameter PRICE, default 6: credit units per vend; SHALL satisfy 0 < PRICE < 2**CW.
REQ-006 SHALL provide port clk, input, 1: the single clock, rising edge.
REQ-007 SHALL provide port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL provide port coin_a, input, 1: coin A inserted; one event per high cycle.
REQ-009 SHALL provide port coin_b, input, 1: coin B inserted; one event per high cycle.
REQ-010 SHALL provide port sel, input, N_ITEMS: product select request, one bit per channel.
REQ-011 SHALL provide port cancel, input, 1: refund request.
REQ-012 SHALL provide port can, output, 1: single-cycle vend pulse.
REQ-013 SHALL provide port item, output, clog2(N_ITEMS) (minimum 1): channel vended, valid while can=1.
REQ-014 SHALL provide port coin_out, output, 1: one pulse per returned credit unit.
REQ-015 SHALL provide port coin_rej, output, 1: single-cycle pulse for each rejected coin.
REQ-016 SHALL provide port busy, output, 1: high in VEND and CHANGE.
REQ-017 SHALL provide port credit, output, CW: current credit register value.

Function
REQ-018 SHALL implement the FSM states ACCUM, VEND and CHANGE, with registered state and credit and combinational outputs.
REQ-019 ACCUM, coin_a XOR coin_b: SHALL add A_VAL or B_VAL to credit next cycle if the sum is at most 2**CW-1; otherwise SHALL leave credit unchanged and pulse coin_rej that cycle.
REQ-020 ACCUM, coin_a and coin_b both high: SHALL accept neither coin and SHALL pulse coin_rej.
REQ-021 ACCUM, sel nonzero with credit >= PRICE: SHALL go to VEND; the request is captured as the lowest-index set bit.
REQ-022 ACCUM, sel nonzero with credit < PRICE: SHALL ignore the request and stay in ACCUM.
REQ-023 Coin and sel in the same ACCUM cycle: the sel test SHALL use the pre-coin credit; the coin SHALL still be accepted per REQ-019.
REQ-024 VEND lasts exactly one cycle: can=1, item=captured index, credit <= credit-PRICE; next state SHALL be CHANGE if the remainder is nonzero, else ACCUM.
REQ-025 CHANGE: SHALL hold coin_out=1 and decrement credit by 1 each cycle; on the cycle credit reaches 1, the next state SHALL be ACCUM with credit 0.
REQ-026 In VEND and CHANGE, coins SHALL be rejected with a coin_rej pulse, and sel and cancel SHALL be ignored.
REQ-027 Vend latency: can SHALL assert 1 cycle after the accepted sel cycle; the first coin_out SHALL assert 2 cycles after it.
REQ-028 When outputs are not asserted as above they SHALL be 0; item SHALL be 0 when can=0.

Reset
REQ-029 rst high SHALL asynchronously force state=ACCUM and credit=0; all outputs SHALL be 0 while rst is high.
REQ-030 Reset during VEND or CHANGE SHALL abort the operation; remaining change is forfeited and no further coin_out pulses occur.

Configuration
REQ-031 SHALL support macro VENMAC_REFUND_EN to compile the refund feature in or out.
REQ-032 With VENMAC_REFUND_EN defined, cancel=1 in ACCUM with credit>0 and sel=0 SHALL go to CHANGE and return the full credit; sel SHALL take priority over cancel; cancel with credit=0 SHALL be ignored.
REQ-033 Without VENMAC_REFUND_EN, the cancel port SHALL remain present and SHALL be ignored.

Structure
REQ-034 Package venmac_pkg SHALL hold the state enum type (ACCUM, VEND, CHANGE) and the default parameter constants.
REQ-035 Sub-module venmac_prio_enc SHALL be the parameterised lowest-index priority encoder used for sel-to-item conversion.

Verification
REQ-036 Defaults; coin_b, then sel=2'b01 -> credit 5, no vend, stays in ACCUM.
REQ-037 Defaults; coin_b, coin_a, then sel=2'b10 -> can=1 and item=1 the next cycle; credit returns to 0; no coin_out pulses.
REQ-038 Defaults; coin_b x2, then sel=2'b11 -> can with item=0, then exactly 4 consecutive coin_out pulses; busy high for 5 cycles.
REQ-039 Defaults; coin_a and coin_b in the same cycle -> coin_rej pulse, credit unchanged; coin_b with credit 60 -> coin_rej, credit stays 60.
REQ-040 VENMAC_REFUND_EN; credit 7, cancel -> 7 coin_out pulses, then ACCUM with credit 0; rst asserted after the 3rd pulse -> pulses stop immediately, credit 0.

Source files
------------

// File: rtl/venmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : venmac_pkg
// Description : Shared state type, default parameters and sizing helper for
//               the parameterised vending-machine controller.
// Revision    : 1.0 - initial release
// ============================================================================
package venmac_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam int c_DEF_N_ITEMS = 2;
    localparam int c_DEF_CW      = 6;
    localparam int c_DEF_A_VAL   = 1;
    localparam int c_DEF_B_VAL   = 5;
    localparam int c_DEF_PRICE   = 6;

    // An item index is always at least one bit wide, even for one channel.
    function automatic int item_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/venmac_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : venmac_prio_enc
// Description : Lowest-index-wins priority encoder for product select bits.
// Revision    : 1.0 - initial release
// ============================================================================
module venmac_prio_enc #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/venmac_param.sv
`default_nettype none
// ============================================================================
// Module      : venmac_param
// Description : Parameterised coin-credit vending controller with vend and
//               change-return sequencing. Define VENMAC_REFUND_EN to enable
//               cancel-driven refund of the full credit.
// Revision    : 1.0 - initial release
// ============================================================================
module venmac_param
    import venmac_pkg::*;
#(
    parameter int N_ITEMS = c_DEF_N_ITEMS,
    parameter int CW      = c_DEF_CW,
    parameter int A_VAL   = c_DEF_A_VAL,
    parameter int B_VAL   = c_DEF_B_VAL,
    parameter int PRICE   = c_DEF_PRICE,
    localparam int IW     = item_w(N_ITEMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_a,
    input  logic               coin_b,
    input  logic [N_ITEMS-1:0] sel,
    input  logic               cancel,
    output logic               can,
    output logic [IW-1:0]      item,
    output logic               coin_out,
    output logic               coin_rej,
    output logic               busy,
    output logic [CW-1:0]      credit
);

    localparam int            c_CMAX  = (1 << CW) - 1;
    localparam bit            c_A_OK  = (A_VAL <= c_CMAX);
    localparam bit            c_B_OK  = (B_VAL <= c_CMAX);
    localparam logic [CW-1:0] c_A_LIM = c_A_OK ? CW'(c_CMAX - A_VAL) : '0;
    localparam logic [CW-1:0] c_B_LIM = c_B_OK ? CW'(c_CMAX - B_VAL) : '0;
    localparam logic [CW-1:0] c_A_CW  = CW'(A_VAL);
    localparam logic [CW-1:0] c_B_CW  = CW'(B_VAL);
    localparam logic [CW-1:0] c_PRICE = CW'(PRICE);

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_credit, w_credit_next;
    logic [IW-1:0] r_item, w_item_next;
    logic [IW-1:0] w_sel_idx;
    logic          w_sel_valid;
    logic          w_fit_a, w_fit_b, w_one_coin, w_accept, w_accum_rej;
    logic [CW-1:0] w_credit_coin, w_remain;

    venmac_prio_enc #(
        .N (N_ITEMS),
        .W (IW)
    ) u_prio_enc (
        .req   (sel),
        .idx   (w_sel_idx),
        .valid (w_sel_valid)
    );

    // Overflow test done against a precomputed limit to keep all math CW wide.
    assign w_fit_a       = c_A_OK && (r_credit <= c_A_LIM);
    assign w_fit_b       = c_B_OK && (r_credit <= c_B_LIM);
    assign w_one_coin    = coin_a ^ coin_b;
    assign w_accept      = w_one_coin && (coin_a ? w_fit_a : w_fit_b);
    assign w_accum_rej   = (coin_a & coin_b) | (w_one_coin & ~w_accept);
    assign w_credit_coin = w_accept ? (r_credit + (coin_a ? c_A_CW : c_B_CW)) : r_credit;
    assign w_remain      = r_credit - c_PRICE;

`ifndef VENMAC_REFUND_EN
    logic w_unused_cancel;
    assign w_unused_cancel = cancel;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_credit_next = r_credit;
        w_item_next   = r_item;
        can           = 1'b0;
        item          = '0;
        coin_out      = 1'b0;
        coin_rej      = 1'b0;
        busy          = 1'b0;
        case (r_state)
            ACCUM: begin
                w_credit_next = w_credit_coin;
                coin_rej      = w_accum_rej;
                // Affordability uses the pre-coin credit.
                if (w_sel_valid && (r_credit >= c_PRICE)) begin
                    w_state_next = VEND;
                    w_item_next  = w_sel_idx;
                end
`ifdef VENMAC_REFUND_EN
                else if (!w_sel_valid && cancel && (r_credit != '0)) begin
                    w_state_next = CHANGE;
                end
`endif
            end
            VEND: begin
                can           = 1'b1;
                item          = r_item;
                busy          = 1'b1;
                coin_rej      = coin_a | coin_b;
                w_credit_next = w_remain;
                w_state_next  = (w_remain != '0) ? CHANGE : ACCUM;
            end
            CHANGE: begin
                coin_out      = 1'b1;
                busy          = 1'b1;
                coin_rej      = coin_a | coin_b;
                w_credit_next = r_credit - CW'(1);
                if (r_credit == CW'(1)) begin
                    w_state_next = ACCUM;
                end
            end
            default: begin
                w_state_next  = ACCUM;
                w_credit_next = '0;
            end
        endcase
        // Input-driven pulses must stay quiet while reset is held.
        if (rst) begin
            can      = 1'b0;
            item     = '0;
            coin_out = 1'b0;
            coin_rej = 1'b0;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ACCUM;
            r_credit <= '0;
            r_item   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_credit <= w_credit_next;
            r_item   <= w_item_next;
        end
    end

    assign credit = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_venmac_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_venmac_param
// Description : Self-checking bench for venmac_param with a schedule-based
//               reference model and directed literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_venmac_param;

    localparam int N  = 2;
    localparam int CW = 6;
    localparam int AV = 1;
    localparam int BV = 5;
    localparam int PR = 6;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_a = 1'b0;
    logic          coin_b = 1'b0;
    logic          cancel = 1'b0;
    logic [N-1:0]  sel = '0;
    logic          can, coin_out, coin_rej, busy;
    logic [0:0]    item;
    logic [CW-1:0] credit;

    int errors = 0;
    int checks = 0;

    logic s_can, s_cout, s_rej, s_busy;
    logic [0:0] s_item;

    venmac_param #(
        .N_ITEMS (N),
        .CW      (CW),
        .A_VAL   (AV),
        .B_VAL   (BV),
        .PRICE   (PR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .coin_a   (coin_a),
        .coin_b   (coin_b),
        .sel      (sel),
        .cancel   (cancel),
        .can      (can),
        .item     (item),
        .coin_out (coin_out),
        .coin_rej (coin_rej),
        .busy     (busy),
        .credit   (credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in ACCUM it applies the coin/sel/cancel rules; an accepted vend
    // or refund expands into a per-cycle list of expected outputs.
    typedef struct {
        bit can;
        int item;
        bit cout;
        int credit;
    } rec_t;

    rec_t sched[$];
    int   m_credit = 0;

    always @(negedge clk) begin : model
        rec_t r;
        int   newc, idx;
        bit   rej;
        if (rst) begin
            chk("rst_can", can, 0);
            chk("rst_cout", coin_out, 0);
            chk("rst_rej", coin_rej, 0);
            chk("rst_busy", busy, 0);
            chk("rst_credit", credit, 0);
            m_credit = 0;
            sched.delete();
        end else if (sched.size() > 0) begin
            r = sched.pop_front();
            chk("m_can", can, r.can);
            chk("m_item", item, r.item);
            chk("m_cout", coin_out, r.cout);
            chk("m_busy", busy, 1);
            chk("m_rej", coin_rej, coin_a | coin_b);
            chk("m_credit", credit, r.credit);
        end else begin
            newc = m_credit;
            rej  = 0;
            if (coin_a && coin_b) rej = 1;
            else if (coin_a || coin_b) begin
                if (m_credit + (coin_a ? AV : BV) <= MAXC) newc = m_credit + (coin_a ? AV : BV);
                else rej = 1;
            end
            chk("m_can", can, 0);
            chk("m_item", item, 0);
            chk("m_cout", coin_out, 0);
            chk("m_busy", busy, 0);
            chk("m_rej", coin_rej, rej);
            chk("m_credit", credit, m_credit);
            if (sel != 0 && m_credit >= PR) begin
                idx = -1;
                for (int i = 0; i < N; i++) if (sel[i] && idx < 0) idx = i;
                sched.push_back('{1, idx, 0, newc});
                for (int c = newc - PR; c > 0; c--) sched.push_back('{0, 0, 1, c});
                m_credit = 0;
            end
`ifdef VENMAC_REFUND_EN
            else if (sel == 0 && cancel && m_credit > 0) begin
                for (int c = newc; c > 0; c--) sched.push_back('{0, 0, 1, c});
                m_credit = 0;
            end
`endif
            else begin
                m_credit = newc;
            end
        end
    end

    // Drive one cycle of inputs, sample outputs mid-cycle, step past the edge.
    task automatic cyc(input bit a, input bit b, input logic [N-1:0] s, input bit c);
        coin_a = a; coin_b = b; sel = s; cancel = c;
        #2;
        s_can = can; s_item = item; s_cout = coin_out; s_rej = coin_rej; s_busy = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0);
    endtask

    task automatic do_reset();
        coin_a = 0; coin_b = 0; sel = '0; cancel = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int cnt_busy, cnt_cout;
        repeat (2) @(posedge clk);
        #1;
        chk("init_credit", credit, 0);
        chk("init_busy", busy, 0);
        rst = 0;

        // coin_b then unaffordable select
        cyc(0, 1, '0, 0);
        chk("b_credit5", credit, 5);
        cyc(0, 0, 2'b01, 0);
        chk("nosel_can", s_can, 0);
        idle();
        chk("nosel_busy", s_busy, 0);
        chk("nosel_credit", credit, 5);
`ifndef VENMAC_REFUND_EN
        cyc(0, 0, '0, 1);
        idle();
        chk("cancel_ign_busy", s_busy, 0);
        chk("cancel_ign_credit", credit, 5);
`endif

        // exact price, item 1, no change
        do_reset();
        cyc(0, 1, '0, 0);
        cyc(1, 0, '0, 0);
        chk("exact_credit6", credit, 6);
        cyc(0, 0, 2'b10, 0);
        chk("exact_sel_can", s_can, 0);
        idle();
        chk("exact_can", s_can, 1);
        chk("exact_item", s_item, 1);
        chk("exact_credit0", credit, 0);
        idle();
        chk("exact_nocout", s_cout, 0);
        chk("exact_idle_busy", s_busy, 0);

        // 10 credits, both selected -> item 0, four change pulses
        do_reset();
        cyc(0, 1, '0, 0);
        cyc(0, 1, '0, 0);
        cyc(0, 0, 2'b11, 0);
        cnt_busy = 0; cnt_cout = 0;
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0) begin
                chk("chg_can", s_can, 1);
                chk("chg_item", s_item, 0);
            end
            cnt_busy += int'(s_busy);
            cnt_cout += int'(s_cout);
        end
        chk("chg_busy_cycles", cnt_busy, 5);
        chk("chg_cout_count", cnt_cout, 4);
        idle();
        chk("chg_end_busy", s_busy, 0);
        chk("chg_end_credit", credit, 0);

        // coin rejection and overflow boundary
        do_reset();
        cyc(1, 1, '0, 0);
        chk("both_rej", s_rej, 1);
        chk("both_credit", credit, 0);
        for (int k = 0; k < 12; k++) cyc(0, 1, '0, 0);
        chk("load60", credit, 60);
        cyc(0, 1, '0, 0);
        chk("ovf_rej", s_rej, 1);
        chk("ovf_credit", credit, 60);
        cyc(1, 0, '0, 0);
        chk("a_at60_rej", s_rej, 0);
        chk("a_at60_credit", credit, 61);

`ifdef VENMAC_REFUND_EN
        do_reset();
        cyc(0, 0, '0, 1);
        idle();
        chk("cancel0_busy", s_busy, 0);
        cyc(0, 1, '0, 0);
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);
        chk("ref_credit7", credit, 7);
        cyc(0, 0, '0, 1);
        cnt_cout = 0;
        for (int k = 0; k < 7; k++) begin
            idle();
            cnt_cout += int'(s_cout);
        end
        chk("ref_cout_count", cnt_cout, 7);
        idle();
        chk("ref_end_cout", s_cout, 0);
        chk("ref_end_credit", credit, 0);
        cyc(0, 1, '0, 0);
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);
        cyc(0, 0, '0, 1);
        for (int k = 0; k < 3; k++) idle();
        rst = 1;
        #1;
        chk("ref_abort_cout", coin_out, 0);
        chk("ref_abort_credit", credit, 0);
        @(posedge clk);
        #1;
        rst = 0;
        idle();
        chk("ref_after_cout", s_cout, 0);
        chk("ref_after_credit", credit, 0);
`endif

        // randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    ($urandom_range(0, 4) == 0) ? N'($urandom) : '0,
                    $urandom_range(0, 7) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
